reg_alu_ctrl: RTL and testbench

Instruction sequencer that sits on the initiator side of the `reg_alu` datapath. It accepts 16-bit instruction words over a valid/ready handshake and decodes each one. It then drives the datapath control and address inputs across a fixed multi-cycle sequence. For read and ALU instructions it returns the result word and the carry over a valid/ready response port.

---
 rtl/reg_alu_ctrl_pkg.sv | 32 +++
 rtl/reg_alu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_reg_alu_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_alu_ctrl_pkg.sv
// Shared definitions for the reg_alu instruction sequencer.
// Holds the datapath widths, the opcode encodings and the sequencer state
// encoding. The glue that pairs reg_alu_ctrl with reg_alu imports this too.
package reg_alu_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 2;

  // Opcode field [15:13] of an instruction word
  localparam logic [2:0] OPC_NOP = 3'b000;
  localparam logic [2:0] OPC_LDI = 3'b001;
  localparam logic [2:0] OPC_RD  = 3'b010;
  localparam logic [2:0] OPC_ILL = 3'b011;
  // ALU instructions are 1oo: only the top opcode bit identifies them
  localparam logic       OPC_ALU = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IMM  = 3'd1,
    ST_WB   = 3'd2,
    ST_EXE  = 3'd3,
    ST_CAP  = 3'd4,
    ST_RD   = 3'd5,
    ST_RESP = 3'd6
  } state_e;

  function automatic logic is_alu(input logic [2:0] opc);
    return opc[2] == OPC_ALU;
  endfunction

endpackage

// File: rtl/reg_alu_ctrl.sv
// reg_alu_ctrl: instruction sequencer driving the reg_alu datapath.
// Accepts 16-bit instruction words over instr_valid/instr_ready, decodes
// them and steps the datapath through a fixed sequence of control states.
// RD and ALU instructions return a result word and carry on the rsp port.
//
// Ports
//   clk, reset          clock (rising edge) and synchronous active-low reset
//   instr_valid/ready   instruction handshake; instr_data carries the word
//                       [15:13] opcode, [12:10] dst, [9:7] srcA, [6:4] srcB
//   rsp_valid/ready     response handshake; rsp_data / rsp_cout payload
//   err                 one-cycle pulse after an illegal opcode is accepted
//   dp_sel, dp_wr       datapath mux select and register write enable
//   dp_op               ALU operation
//   dp_rd_addr_a/b      datapath read addresses
//   dp_wr_addr          datapath write address
//   dp_d_in             immediate presented to the datapath
//   dp_d_out_a, dp_cout datapath read port A and registered carry
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic              err,
  output logic              dp_sel,
  output logic              dp_wr,
  output logic [OP_W-1:0]   dp_op,
  output logic [ADDR_W-1:0] dp_rd_addr_a,
  output logic [ADDR_W-1:0] dp_rd_addr_b,
  output logic [ADDR_W-1:0] dp_wr_addr,
  output logic [DATA_W-1:0] dp_d_in,
  input  logic [DATA_W-1:0] dp_d_out_a,
  input  logic              dp_cout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] srca_q, srca_d;
  logic [ADDR_W-1:0] srcb_q, srcb_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              err_q, err_d;
  logic              ready_int;

  logic [2:0] opc;
  logic       unused_low_bits;

  assign opc             = instr_data[15:13];
  // The low nibble of an instruction word carries no meaning
  assign unused_low_bits = ^instr_data[3:0];

  // Next-state logic: decode on accept in IDLE, latch the immediate in IMM,
  // capture the response word in CAP/RD and hold it until it is consumed.
  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    op_d       = op_q;
    imm_d      = imm_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          dst_d  = instr_data[12:10];
          srca_d = instr_data[9:7];
          srcb_d = instr_data[6:4];
          op_d   = instr_data[14:13];
          if (is_alu(opc)) begin
            state_d = ST_EXE;
          end else begin
            case (opc)
              OPC_LDI: state_d = ST_IMM;
              OPC_RD:  state_d = ST_RD;
              OPC_ILL: err_d   = 1'b1;
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_IMM: begin
        if (instr_valid) begin
          imm_d   = instr_data;
          state_d = ST_WB;
        end
      end
      ST_WB:  state_d = ST_IDLE;
      ST_EXE: state_d = ST_CAP;
      ST_CAP: begin
        // The write landed at the end of EXE, so reading dst here returns
        // the new value even when dst aliases a source register.
        rsp_data_d = dp_d_out_a;
        rsp_cout_d = dp_cout;
        state_d    = ST_RESP;
      end
      ST_RD: begin
        rsp_data_d = dp_d_out_a;
        rsp_cout_d = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state and the latched fields. The write
  // enable and ready are also masked by reset so a write pending in the
  // cycle that reset is sampled never reaches the register file.
  always_comb begin
    ready_int    = 1'b0;
    rsp_valid    = 1'b0;
    dp_wr        = 1'b0;
    dp_sel       = 1'b0;
    dp_op        = '0;
    dp_rd_addr_a = '0;
    dp_rd_addr_b = '0;
    dp_wr_addr   = '0;

    case (state_q)
      ST_IDLE, ST_IMM: ready_int = 1'b1;
      ST_WB: begin
        dp_wr      = reset;
        dp_wr_addr = dst_q;
      end
      ST_EXE: begin
        dp_wr        = reset;
        dp_sel       = 1'b1;
        dp_op        = op_q;
        dp_rd_addr_a = srca_q;
        dp_rd_addr_b = srcb_q;
        dp_wr_addr   = dst_q;
      end
      ST_CAP:  dp_rd_addr_a = dst_q;
      ST_RD:   dp_rd_addr_a = srca_q;
      ST_RESP: rsp_valid    = 1'b1;
      default: ;
    endcase
  end

  assign instr_ready = ready_int & reset;
  assign dp_d_in     = imm_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cout    = rsp_cout_q;
  assign err         = err_q;

  // State, field, immediate and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      op_q       <= '0;
      imm_q      <= '0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Testbench for reg_alu_ctrl: a behavioural reg_alu register file sits on
// the datapath side, and a shadow register array predicts every response.
module tb_reg_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_cout;
  logic        err;
  logic        dp_sel;
  logic        dp_wr;
  logic [1:0]  dp_op;
  logic [2:0]  dp_rd_addr_a;
  logic [2:0]  dp_rd_addr_b;
  logic [2:0]  dp_wr_addr;
  logic [15:0] dp_d_in;
  logic [15:0] dp_d_out_a;
  logic        dp_cout;

  int errors = 0;
  int checks = 0;

  logic [15:0] dp_regs [8] = '{default: 16'h0000};
  logic        dp_carry = 1'b0;
  logic [15:0] ref_regs [8] = '{default: 16'h0000};

  reg_alu_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_cout     (rsp_cout),
    .err          (err),
    .dp_sel       (dp_sel),
    .dp_wr        (dp_wr),
    .dp_op        (dp_op),
    .dp_rd_addr_a (dp_rd_addr_a),
    .dp_rd_addr_b (dp_rd_addr_b),
    .dp_wr_addr   (dp_wr_addr),
    .dp_d_in      (dp_d_in),
    .dp_d_out_a   (dp_d_out_a),
    .dp_cout      (dp_cout)
  );

  always #5 clk = ~clk;

  // Team ALU encoding: 00 add, 01 sub, 10 and, 11 or; carry from add/sub
  function automatic logic [16:0] refAlu(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic [15:0] mkWord(input logic [2:0] opc,
                                         input logic [2:0] d,
                                         input logic [2:0] a,
                                         input logic [2:0] b);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {opc, d, a, b, junk};
  endfunction

  // Behavioural reg_alu: combinational read port A, write at the clock edge
  assign dp_d_out_a = dp_regs[dp_rd_addr_a];
  assign dp_cout    = dp_carry;

  always @(posedge clk) begin
    if (dp_wr) begin
      if (dp_sel)
        {dp_carry, dp_regs[dp_wr_addr]} <= refAlu(dp_op, dp_regs[dp_rd_addr_a], dp_regs[dp_rd_addr_b]);
      else
        dp_regs[dp_wr_addr] <= dp_d_in;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"},
                {instr_ready, rsp_valid, rsp_cout, err, dp_sel, dp_wr, dp_op,
                 dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr}, 64'h0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 64'h0);
    checkOutput({tag, "_dp_d_in"}, dp_d_in, 64'h0);
  endtask

  // Offers a word and returns at the falling edge after its accept edge
  task automatic applyStimulus(input logic [15:0] w);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr_data  = w;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_timeout", instr_ready, 64'h1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
  endtask

  // Waits for the response; lat counts edges after the accept edge
  task automatic waitResponse(input int stall, output logic [15:0] d,
                              output logic c, output int lat);
    lat = 0;
    rsp_ready = (stall == 0);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_timeout", rsp_valid, 64'h1);
    d = rsp_data;
    c = rsp_cout;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("rsp_hold", {rsp_valid, instr_ready, rsp_cout, rsp_data},
                  {1'b1, 1'b0, c, d});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_done_idle", {rsp_valid, instr_ready}, {1'b0, 1'b1});
  endtask

  task automatic doLdi(input logic [2:0] dst, input logic [15:0] imm, input int gap);
    applyStimulus(mkWord(3'b001, dst, 3'($urandom), 3'($urandom)));
    checkOutput("ldi_imm_state", {instr_ready, dp_wr, rsp_valid}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      checkOutput("ldi_imm_wait", {instr_ready, dp_wr}, {1'b1, 1'b0});
    end
    applyStimulus(imm);
    checkOutput("ldi_wb", {instr_ready, dp_wr, dp_sel, dp_wr_addr, dp_d_in},
                {1'b0, 1'b1, 1'b0, dst, imm});
    @(negedge clk);
    checkOutput("ldi_back_idle", {instr_ready, dp_wr}, {1'b1, 1'b0});
    ref_regs[dst] = imm;
  endtask

  task automatic doRd(input logic [2:0] src, input int stall);
    logic [15:0] d;
    logic        c;
    int          lat;
    applyStimulus(mkWord(3'b010, 3'($urandom), src, 3'($urandom)));
    checkOutput("rd_state", {instr_ready, dp_wr, dp_rd_addr_a}, {1'b0, 1'b0, src});
    waitResponse(stall, d, c, lat);
    checkOutput("rd_latency", lat, 64'd1);
    checkOutput("rd_data", d, ref_regs[src]);
    checkOutput("rd_cout", c, 64'h0);
  endtask

  task automatic doAlu(input logic [1:0] op, input logic [2:0] dst,
                       input logic [2:0] a, input logic [2:0] b, input int stall);
    logic [16:0] exp;
    logic [15:0] d;
    logic        c;
    int          lat;
    exp = refAlu(op, ref_regs[a], ref_regs[b]);
    applyStimulus(mkWord({1'b1, op}, dst, a, b));
    checkOutput("alu_exe", {instr_ready, dp_wr, dp_sel, dp_op, dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr},
                {1'b0, 1'b1, 1'b1, op, a, b, dst});
    ref_regs[dst] = exp[15:0];
    waitResponse(stall, d, c, lat);
    checkOutput("alu_latency", lat, 64'd2);
    checkOutput("alu_data", d, exp[15:0]);
    checkOutput("alu_cout", c, exp[16]);
  endtask

  initial begin
    int kind;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 16'h0;
    rsp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset_state");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", instr_ready, 64'h1);

    $display("[TB] directed: LDI/LDI/ADD with carry out");
    doLdi(3'd1, 16'h00FF, 0);
    doLdi(3'd2, 16'hFF01, 0);
    doAlu(2'b00, 3'd3, 3'd1, 3'd2, 0);
    checkOutput("r3_model", ref_regs[3], 64'h0);
    doRd(3'd3, 0);

    $display("[TB] directed: RD with stalled consumer");
    doRd(3'd1, 5);

    $display("[TB] directed: illegal opcode");
    applyStimulus(mkWord(3'b011, 3'd5, 3'd1, 3'd2));
    checkOutput("illegal_err", {err, dp_wr, instr_ready}, {1'b1, 1'b0, 1'b1});
    @(negedge clk);
    checkOutput("illegal_err_clear", {err, dp_wr, instr_ready}, {1'b0, 1'b0, 1'b1});

    $display("[TB] directed: NOP");
    applyStimulus(mkWord(3'b000, 3'd4, 3'd4, 3'd4));
    checkOutput("nop_idle", {instr_ready, err, dp_wr, rsp_valid}, {1'b1, 1'b0, 1'b0, 1'b0});

    $display("[TB] directed: aliased ADD r1=r1+r1");
    doLdi(3'd1, 16'h0003, 2);
    doAlu(2'b00, 3'd1, 3'd1, 3'd1, 1);
    checkOutput("alias_model", ref_regs[1], 64'h6);

    $display("[TB] directed: reset during EXE");
    applyStimulus(mkWord(3'b100, 3'd2, 3'd1, 3'd1));
    checkOutput("exe_before_reset", dp_wr, 64'h1);
    reset = 1'b0;
    #1;
    checkOutput("exe_wr_suppressed", dp_wr, 64'h0);
    @(negedge clk);
    checkAllZero("reset_mid_exe");
    reset = 1'b1;
    @(negedge clk);
    doRd(3'd2, 0);

    $display("[TB] random instruction stream");
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        applyStimulus(mkWord(3'b000, 3'($urandom), 3'($urandom), 3'($urandom)));
        checkOutput("rand_nop", {instr_ready, err, dp_wr}, {1'b1, 1'b0, 1'b0});
      end else if (kind <= 2) begin
        doLdi(3'($urandom), 16'($urandom), $urandom_range(0, 2));
      end else if (kind <= 4) begin
        doRd(3'($urandom), $urandom_range(0, 3));
      end else if (kind <= 8) begin
        doAlu(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 3));
      end else begin
        applyStimulus(mkWord(3'b011, 3'($urandom), 3'($urandom), 3'($urandom)));
        checkOutput("rand_illegal", {err, dp_wr, instr_ready}, {1'b1, 1'b0, 1'b1});
        @(negedge clk);
        checkOutput("rand_illegal_clear", err, 64'h0);
      end
    end

    for (int r = 0; r < 8; r++) begin
      doRd(3'(r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
